// File: rtl/memory_arbiter_pkg.sv
// Shared types for the instruction/data memory arbiter: FSM states, memory
// bus command codes and requester identifiers.
package memory_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ACCESS   = 2'd1,
    S_WAIT_MFC = 2'd2,
    S_DONE     = 2'd3
  } state_e;

  localparam logic [1:0] MEM_READ  = 2'b00;
  localparam logic [1:0] MEM_WRITE = 2'b01;
  localparam logic [1:0] MEM_HIZ   = 2'b10;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_DM = 1'b1
  } req_id_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter; on a tie the requester not granted last wins.
module rr_arbiter2
  import memory_arbiter_pkg::*;
(
  input  logic    clk_i,
  input  logic    rst_i,
  input  logic    req_if_i,
  input  logic    req_dm_i,
  input  logic    accept_i,
  output logic    valid_o,
  output req_id_e grant_o
);

  req_id_e last_q, last_d;

  always_comb begin
    valid_o = req_if_i | req_dm_i;
    grant_o = REQ_IF;
    if (req_if_i && req_dm_i) begin
      grant_o = (last_q == REQ_IF) ? REQ_DM : REQ_IF;
    end else if (req_dm_i) begin
      grant_o = REQ_DM;
    end
  end

  always_comb begin
    last_d = last_q;
    if (accept_i && valid_o) begin
      last_d = grant_o;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_q <= REQ_IF;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Arbitrates instruction-fetch and data requests onto a single memory port
// with MFC handshake, address pre-check, error reporting and timeout.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 8,
  parameter int unsigned ADDR_LIMIT     = 127
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        IF_Req,
  input  logic [31:0] IF_Address,
  output logic        IF_Ack,
  output logic [31:0] IF_Data,
  input  logic        DM_Req,
  input  logic        DM_Write,
  input  logic [31:0] DM_Address,
  input  logic [31:0] DM_Data_In,
  output logic        DM_Ack,
  output logic [31:0] DM_Data_Out,
  output logic        Error,
  output logic [31:0] MEM_Address,
  output logic [31:0] MEM_Data_In,
  output logic [1:0]  MEM_r_w_z_z,
  input  logic [31:0] MEM_Data_Out,
  input  logic        MEM_MFC,
  input  logic        MEM_ERROR,
  output logic        Busy
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic        if_ack_q, if_ack_d;
  logic        dm_ack_q, dm_ack_d;
  logic        err_q, err_d;
  logic [31:0] if_data_q, if_data_d;
  logic [31:0] dm_data_q, dm_data_d;

  req_id_e     owner_q, owner_d;
  logic        write_q, write_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  logic        arb_valid;
  req_id_e     arb_grant;
  logic        arb_accept;
  logic        finish;

  assign arb_accept = (state_q == S_IDLE);

  rr_arbiter2 u_arb (
    .clk_i    (Clock),
    .rst_i    (Reset),
    .req_if_i (IF_Req),
    .req_dm_i (DM_Req),
    .accept_i (arb_accept),
    .valid_o  (arb_valid),
    .grant_o  (arb_grant)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_d     = 1'b0;
    if_data_d = if_data_q;
    dm_data_d = dm_data_q;
    owner_d   = owner_q;
    write_d   = write_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    finish    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (arb_valid) begin
          owner_d = arb_grant;
          state_d = S_ACCESS;
          if (arb_grant == REQ_DM) begin
            addr_d  = DM_Address;
            write_d = DM_Write;
            wdata_d = DM_Data_In;
          end else begin
            addr_d  = IF_Address;
            write_d = 1'b0;
          end
        end
      end
      S_ACCESS: begin
        if (MEM_ERROR || (addr_q > ADDR_LIMIT)) begin
          err_d   = 1'b1;
          finish  = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d   = '0;
          state_d = S_WAIT_MFC;
        end
      end
      S_WAIT_MFC: begin
        if (MEM_MFC) begin
          finish  = 1'b1;
          state_d = S_DONE;
          // Write completions leave both read-data outputs untouched.
          if (!write_q) begin
            if (owner_q == REQ_DM) dm_data_d = MEM_Data_Out;
            else                   if_data_d = MEM_Data_Out;
          end
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          finish  = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Acks are registered so they are high exactly during the DONE cycle.
    if_ack_d = finish && (owner_q == REQ_IF);
    dm_ack_d = finish && (owner_q == REQ_DM);
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      if_ack_q  <= 1'b0;
      dm_ack_q  <= 1'b0;
      err_q     <= 1'b0;
      if_data_q <= '0;
      dm_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      if_ack_q  <= if_ack_d;
      dm_ack_q  <= dm_ack_d;
      err_q     <= err_d;
      if_data_q <= if_data_d;
      dm_data_q <= dm_data_d;
    end
  end

  // Latched access descriptor; only meaningful outside IDLE, so no reset.
  always_ff @(posedge Clock) begin
    owner_q <= owner_d;
    write_q <= write_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  always_comb begin
    MEM_r_w_z_z = MEM_HIZ;
    if ((state_q == S_ACCESS) || (state_q == S_WAIT_MFC)) begin
      MEM_r_w_z_z = write_q ? MEM_WRITE : MEM_READ;
    end
  end

  assign MEM_Address = addr_q;
  assign MEM_Data_In = wdata_q;
  assign IF_Ack      = if_ack_q;
  assign DM_Ack      = dm_ack_q;
  assign Error       = err_q;
  assign IF_Data     = if_data_q;
  assign DM_Data_Out = dm_data_q;
  assign Busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter with a small ROM/RAM memory model.
module tb_memory_arbiter;

  logic        Clock;
  logic        Reset;
  logic        IF_Req;
  logic [31:0] IF_Address;
  logic        IF_Ack;
  logic [31:0] IF_Data;
  logic        DM_Req;
  logic        DM_Write;
  logic [31:0] DM_Address;
  logic [31:0] DM_Data_In;
  logic        DM_Ack;
  logic [31:0] DM_Data_Out;
  logic        Error;
  logic [31:0] MEM_Address;
  logic [31:0] MEM_Data_In;
  logic [1:0]  MEM_r_w_z_z;
  logic [31:0] MEM_Data_Out;
  logic        MEM_MFC;
  logic        MEM_ERROR;
  logic        Busy;

  int tests_run;
  int tests_failed;
  int overlap;
  bit mfc_en;
  bit err_en;

  logic [31:0] ram [0:255];
  bit   [255:0] wr_valid;
  logic [7:0]  maddr;

  memory_arbiter #(.TIMEOUT_CYCLES(8), .ADDR_LIMIT(127)) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .IF_Req       (IF_Req),
    .IF_Address   (IF_Address),
    .IF_Ack       (IF_Ack),
    .IF_Data      (IF_Data),
    .DM_Req       (DM_Req),
    .DM_Write     (DM_Write),
    .DM_Address   (DM_Address),
    .DM_Data_In   (DM_Data_In),
    .DM_Ack       (DM_Ack),
    .DM_Data_Out  (DM_Data_Out),
    .Error        (Error),
    .MEM_Address  (MEM_Address),
    .MEM_Data_In  (MEM_Data_In),
    .MEM_r_w_z_z  (MEM_r_w_z_z),
    .MEM_Data_Out (MEM_Data_Out),
    .MEM_MFC      (MEM_MFC),
    .MEM_ERROR    (MEM_ERROR),
    .Busy         (Busy)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Memory model: unwritten words read back as 0x1000_0000 | address.
  assign maddr        = MEM_Address[7:0];
  assign MEM_Data_Out = wr_valid[maddr] ? ram[maddr] : (32'h1000_0000 | {24'h0, maddr});
  assign MEM_MFC      = mfc_en && (MEM_r_w_z_z != 2'b10);
  assign MEM_ERROR    = err_en;

  always @(posedge Clock) begin
    if (MEM_r_w_z_z == 2'b01 && MEM_MFC) begin
      ram[maddr]      <= MEM_Data_In;
      wr_valid[maddr] <= 1'b1;
    end
  end

  always @(negedge Clock) begin
    if (IF_Ack && DM_Ack) overlap++;
  end

  task automatic run_access(input bit dm, input bit wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input bit drop_early,
                            output int cyc, output logic [1:0] code2,
                            output logic [31:0] addr2, output logic err);
    cyc = -1; code2 = 2'bxx; addr2 = 'x; err = 1'bx;
    @(posedge Clock); #1;
    if (dm) begin
      DM_Req = 1'b1; DM_Write = wr; DM_Address = addr; DM_Data_In = wdata;
    end else begin
      IF_Req = 1'b1; IF_Address = addr;
    end
    for (int i = 1; i <= 40; i++) begin
      @(negedge Clock);
      if (i == 2) begin code2 = MEM_r_w_z_z; addr2 = MEM_Address; end
      if ((dm && DM_Ack) || (!dm && IF_Ack)) begin
        cyc = i; err = Error;
        break;
      end
      if (drop_early && i == 1) begin
        @(posedge Clock); #1;
        if (dm) DM_Req = 1'b0; else IF_Req = 1'b0;
      end
    end
    @(posedge Clock); #1;
    if (dm) DM_Req = 1'b0; else IF_Req = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b0;
    @(negedge Clock);
    tests_run++; if (IF_Ack !== 1'b0) begin tests_failed++; $display("FAIL rst_if_ack got %0h exp 0", IF_Ack); end
    tests_run++; if (DM_Ack !== 1'b0) begin tests_failed++; $display("FAIL rst_dm_ack got %0h exp 0", DM_Ack); end
    tests_run++; if (Error !== 1'b0) begin tests_failed++; $display("FAIL rst_error got %0h exp 0", Error); end
    tests_run++; if (Busy !== 1'b0) begin tests_failed++; $display("FAIL rst_busy got %0h exp 0", Busy); end
    tests_run++; if (MEM_r_w_z_z !== 2'b10) begin tests_failed++; $display("FAIL rst_code got %b exp 10", MEM_r_w_z_z); end
    tests_run++; if (IF_Data !== 32'h0) begin tests_failed++; $display("FAIL rst_if_data got %h exp 0", IF_Data); end
    tests_run++; if (DM_Data_Out !== 32'h0) begin tests_failed++; $display("FAIL rst_dm_data got %h exp 0", DM_Data_Out); end
  endtask

  task automatic test_fetch();
    int c; logic [1:0] code; logic [31:0] a; logic e;
    run_access(1'b0, 1'b0, 32'h05, 32'h0, 1'b0, c, code, a, e);
    tests_run++; if (c !== 4) begin tests_failed++; $display("FAIL fetch_latency got %0d exp 4", c); end
    tests_run++; if (code !== 2'b00) begin tests_failed++; $display("FAIL fetch_code got %b exp 00", code); end
    tests_run++; if (a !== 32'h05) begin tests_failed++; $display("FAIL fetch_addr got %h exp 5", a); end
    tests_run++; if (IF_Data !== 32'h1000_0005) begin tests_failed++; $display("FAIL fetch_data got %h exp 10000005", IF_Data); end
    tests_run++; if (e !== 1'b0) begin tests_failed++; $display("FAIL fetch_error got %0h exp 0", e); end
  endtask

  task automatic test_write_read();
    int c; logic [1:0] code; logic [31:0] a; logic e;
    run_access(1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF, 1'b0, c, code, a, e);
    tests_run++; if (c !== 4) begin tests_failed++; $display("FAIL wr_latency got %0d exp 4", c); end
    tests_run++; if (code !== 2'b01) begin tests_failed++; $display("FAIL wr_code got %b exp 01", code); end
    tests_run++; if (a !== 32'h40) begin tests_failed++; $display("FAIL wr_addr got %h exp 40", a); end
    tests_run++; if (e !== 1'b0) begin tests_failed++; $display("FAIL wr_error got %0h exp 0", e); end
    tests_run++; if (DM_Data_Out !== 32'h0) begin tests_failed++; $display("FAIL wr_dm_hold got %h exp 0", DM_Data_Out); end
    tests_run++; if (IF_Data !== 32'h1000_0005) begin tests_failed++; $display("FAIL wr_if_hold got %h exp 10000005", IF_Data); end
    run_access(1'b1, 1'b0, 32'h40, 32'h0, 1'b0, c, code, a, e);
    tests_run++; if (code !== 2'b00) begin tests_failed++; $display("FAIL rd_code got %b exp 00", code); end
    tests_run++; if (c !== 4) begin tests_failed++; $display("FAIL rd_latency got %0d exp 4", c); end
    tests_run++; if (DM_Data_Out !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL rd_data got %h exp deadbeef", DM_Data_Out); end
  endtask

  task automatic test_tie();
    int dm_c, if_c, ov0;
    logic [31:0] dm_d, if_d;
    Reset = 1'b1;
    @(posedge Clock); @(negedge Clock);
    Reset = 1'b0;
    dm_c = -1; if_c = -1; ov0 = overlap;
    @(posedge Clock); #1;
    IF_Req = 1'b1; IF_Address = 32'h07;
    DM_Req = 1'b1; DM_Write = 1'b0; DM_Address = 32'h10;
    for (int i = 1; i <= 30; i++) begin
      @(negedge Clock);
      if (DM_Ack && dm_c < 0) begin
        dm_c = i; dm_d = DM_Data_Out;
        @(posedge Clock); #1; DM_Req = 1'b0;
      end else if (IF_Ack && if_c < 0) begin
        if_c = i; if_d = IF_Data;
        @(posedge Clock); #1; IF_Req = 1'b0;
      end
      if (dm_c > 0 && if_c > 0) break;
    end
    IF_Req = 1'b0; DM_Req = 1'b0;
    tests_run++; if (dm_c !== 4) begin tests_failed++; $display("FAIL tie_dm_first got %0d exp 4", dm_c); end
    tests_run++; if (if_c !== 8) begin tests_failed++; $display("FAIL tie_if_second got %0d exp 8", if_c); end
    tests_run++; if (dm_d !== 32'h1000_0010) begin tests_failed++; $display("FAIL tie_dm_data got %h exp 10000010", dm_d); end
    tests_run++; if (if_d !== 32'h1000_0007) begin tests_failed++; $display("FAIL tie_if_data got %h exp 10000007", if_d); end
    tests_run++; if (overlap !== ov0) begin tests_failed++; $display("FAIL tie_ack_overlap got %0d exp %0d", overlap, ov0); end
  endtask

  task automatic test_errors();
    int c; logic [1:0] code; logic [31:0] a; logic e;
    err_en = 1'b1;
    run_access(1'b1, 1'b0, 32'h80, 32'h0, 1'b0, c, code, a, e);
    err_en = 1'b0;
    tests_run++; if (c !== 3) begin tests_failed++; $display("FAIL memerr_latency got %0d exp 3", c); end
    tests_run++; if (e !== 1'b1) begin tests_failed++; $display("FAIL memerr_error got %0h exp 1", e); end
    tests_run++; if (DM_Data_Out !== 32'h1000_0010) begin tests_failed++; $display("FAIL memerr_dm_hold got %h exp 10000010", DM_Data_Out); end
    run_access(1'b0, 1'b0, 32'h80, 32'h0, 1'b0, c, code, a, e);
    tests_run++; if (c !== 3) begin tests_failed++; $display("FAIL limit_latency got %0d exp 3", c); end
    tests_run++; if (e !== 1'b1) begin tests_failed++; $display("FAIL limit_error got %0h exp 1", e); end
    tests_run++; if (IF_Data !== 32'h1000_0007) begin tests_failed++; $display("FAIL limit_if_hold got %h exp 10000007", IF_Data); end
    run_access(1'b0, 1'b0, 32'h7F, 32'h0, 1'b0, c, code, a, e);
    tests_run++; if (c !== 4) begin tests_failed++; $display("FAIL edge_latency got %0d exp 4", c); end
    tests_run++; if (e !== 1'b0) begin tests_failed++; $display("FAIL edge_error got %0h exp 0", e); end
    tests_run++; if (IF_Data !== 32'h1000_007F) begin tests_failed++; $display("FAIL edge_data got %h exp 1000007f", IF_Data); end
  endtask

  task automatic test_timeout();
    int c; logic [1:0] code; logic [31:0] a; logic e;
    mfc_en = 1'b0;
    run_access(1'b0, 1'b0, 32'h03, 32'h0, 1'b0, c, code, a, e);
    mfc_en = 1'b1;
    tests_run++; if (c !== 11) begin tests_failed++; $display("FAIL timeout_latency got %0d exp 11", c); end
    tests_run++; if (e !== 1'b1) begin tests_failed++; $display("FAIL timeout_error got %0h exp 1", e); end
    tests_run++; if (IF_Data !== 32'h1000_007F) begin tests_failed++; $display("FAIL timeout_if_hold got %h exp 1000007f", IF_Data); end
  endtask

  task automatic test_back_to_back();
    int c1, c2; logic [31:0] d1, d2; logic gap_busy;
    int c; logic [1:0] code; logic [31:0] a; logic e;
    c1 = -1; c2 = -1; gap_busy = 1'bx;
    @(posedge Clock); #1;
    IF_Req = 1'b1; IF_Address = 32'h0B;
    for (int i = 1; i <= 30; i++) begin
      @(negedge Clock);
      if (c1 > 0 && i == c1 + 1) gap_busy = Busy;
      if (IF_Ack) begin
        if (c1 < 0) begin
          c1 = i; d1 = IF_Data; IF_Address = 32'h0C;
        end else begin
          c2 = i; d2 = IF_Data;
          break;
        end
      end
    end
    @(posedge Clock); #1; IF_Req = 1'b0;
    tests_run++; if (c1 !== 4) begin tests_failed++; $display("FAIL b2b_first got %0d exp 4", c1); end
    tests_run++; if (c2 !== 8) begin tests_failed++; $display("FAIL b2b_second got %0d exp 8", c2); end
    tests_run++; if (gap_busy !== 1'b0) begin tests_failed++; $display("FAIL b2b_idle_gap got %0h exp 0", gap_busy); end
    tests_run++; if (d1 !== 32'h1000_000B) begin tests_failed++; $display("FAIL b2b_data1 got %h exp 1000000b", d1); end
    tests_run++; if (d2 !== 32'h1000_000C) begin tests_failed++; $display("FAIL b2b_data2 got %h exp 1000000c", d2); end
    run_access(1'b1, 1'b1, 32'h01, 32'h1234_5678, 1'b1, c, code, a, e);
    tests_run++; if (c !== 4) begin tests_failed++; $display("FAIL drop_ack got %0d exp 4", c); end
    tests_run++; if (e !== 1'b0) begin tests_failed++; $display("FAIL rom_write_error got %0h exp 0", e); end
    tests_run++; if (DM_Data_Out !== 32'h1000_0010) begin tests_failed++; $display("FAIL drop_dm_hold got %h exp 10000010", DM_Data_Out); end
  endtask

  task automatic test_reset_mid();
    int c; logic [31:0] d; int acks_in_reset;
    c = -1; acks_in_reset = 0;
    mfc_en = 1'b0;
    @(posedge Clock); #1;
    IF_Req = 1'b1; IF_Address = 32'h09;
    repeat (4) @(negedge Clock);
    tests_run++; if (Busy !== 1'b1) begin tests_failed++; $display("FAIL mid_busy_wait got %0h exp 1", Busy); end
    #1 Reset = 1'b1;
    #1;
    tests_run++; if (Busy !== 1'b0) begin tests_failed++; $display("FAIL mid_busy got %0h exp 0", Busy); end
    tests_run++; if (MEM_r_w_z_z !== 2'b10) begin tests_failed++; $display("FAIL mid_code got %b exp 10", MEM_r_w_z_z); end
    tests_run++; if (IF_Data !== 32'h0) begin tests_failed++; $display("FAIL mid_if_data got %h exp 0", IF_Data); end
    tests_run++; if (DM_Data_Out !== 32'h0) begin tests_failed++; $display("FAIL mid_dm_data got %h exp 0", DM_Data_Out); end
    @(posedge Clock);
    @(negedge Clock);
    if (IF_Ack) acks_in_reset++;
    Reset = 1'b0;
    mfc_en = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge Clock);
      if (IF_Ack) begin c = i; d = IF_Data; break; end
    end
    @(posedge Clock); #1; IF_Req = 1'b0;
    tests_run++; if (acks_in_reset !== 0) begin tests_failed++; $display("FAIL mid_no_ack got %0d exp 0", acks_in_reset); end
    tests_run++; if (c !== 3) begin tests_failed++; $display("FAIL mid_reserve got %0d exp 3", c); end
    tests_run++; if (d !== 32'h1000_0009) begin tests_failed++; $display("FAIL mid_data got %h exp 10000009", d); end
  endtask

  initial begin
    tests_run = 0; tests_failed = 0; overlap = 0;
    mfc_en = 1'b1; err_en = 1'b0;
    Reset = 1'b1;
    IF_Req = 1'b0; IF_Address = '0;
    DM_Req = 1'b0; DM_Write = 1'b0; DM_Address = '0; DM_Data_In = '0;
    test_reset();
    test_fetch();
    test_write_read();
    test_tie();
    test_errors();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    tests_run++; if (overlap !== 0) begin tests_failed++; $display("FAIL ack_overlap_total got %0d exp 0", overlap); end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 8: WAIT_MFC cycles allowed before an access is failed.
REQ-002 Parameter ADDR_LIMIT, default 127: highest legal word address, used for pre-check only.
REQ-003 Clock  input  1  single system clock; all state changes on rising edge.
REQ-004 Reset  input  1  asynchronous, active-high reset.
REQ-005 IF_Req  input  1  instruction-fetch read request, held until IF_Ack.
REQ-006 IF_Address  input  32  fetch word address (from PC).
REQ-007 IF_Ack  output  1  one-cycle completion pulse for fetch.
REQ-008 IF_Data  output  32  fetched word, valid when IF_Ack=1.
REQ-009 DM_Req  input  1  data request, held until DM_Ack.
REQ-010 DM_Write  input  1  1=write, 0=read.
REQ-011 DM_Address  input  32  data word address (from RZ).
REQ-012 DM_Data_In  input  32  write data.
REQ-013 DM_Ack  output  1  one-cycle completion pulse for data.
REQ-014 DM_Data_Out  output  32  read word, valid when DM_Ack=1.
REQ-015 Error  output  1  access failed (MEM_ERROR or timeout), valid with the corresponding Ack.
REQ-016 MEM_Address, MEM_Data_In  output  32 each  to memory interface.
REQ-017 MEM_r_w_z_z  output  2  00 read, 01 write, 10 idle/high-Z.
REQ-018 MEM_Data_Out  input  32; MEM_MFC, MEM_ERROR  input  1 each  from memory interface.
REQ-019 Busy  output  1  high in any state other than IDLE.

Function
REQ-020 FSM states: IDLE, ACCESS, WAIT_MFC, DONE.
REQ-021 IDLE: MEM_r_w_z_z=10; on any request, grant, latch address/data/direction/requester, go to ACCESS.
REQ-022 Arbitration: single requester wins; with both pending, grant the requester not granted last (last_grant resets to IF, so DM wins the first tie).
REQ-023 ACCESS: drive latched address and data, MEM_r_w_z_z=00 (read) or 01 (write); if MEM_ERROR=1 or address>ADDR_LIMIT, set Error and go to DONE, otherwise go to WAIT_MFC.
REQ-024 WAIT_MFC: hold address, data and code; on MEM_MFC=1 capture MEM_Data_Out (reads) and go to DONE.
REQ-025 Timeout: counter clears on entry to WAIT_MFC and increments each cycle; on reaching TIMEOUT_CYCLES without MFC, set Error and go to DONE.
REQ-026 DONE: pulse exactly one Ack for the granted requester; drive captured data on that requester's data output; MEM_r_w_z_z=10; return to IDLE.
REQ-027 Latency: request first seen in IDLE at edge N gives Ack high in the cycle after edge N+3 when MFC=1 on the first WAIT_MFC cycle; the requester must see Ack no earlier than the 4th cycle.
REQ-028 Back-to-back: a request still held in IDLE after DONE is re-arbitrated, so minimum spacing is one IDLE cycle between accesses.
REQ-029 Request dropped before Ack: the latched access completes and Ack still pulses; the requester ignores it.
REQ-030 Write data is never captured into IF_Data or DM_Data_Out; on a write Ack the data outputs hold their previous value.
REQ-031 Writes to ROM space complete normally, with no Error.
REQ-032 IF_Ack and DM_Ack are never high in the same cycle.

Reset
REQ-033 Reset takes the FSM to IDLE, MEM_r_w_z_z=10, all Ack, Error and Busy outputs 0, data outputs 0, counter 0, last_grant=IF.
REQ-034 Reset mid-access abandons the access with no Ack; held requests are re-arbitrated on the first edge after release.

Structure
REQ-035 Shared package memory_arbiter_pkg holds the state enum, the MEM_r_w_z_z codes (READ, WRITE, HIZ) and the requester IDs.
REQ-036 One sub-module, rr_arbiter2, provides two-input round-robin grant with a last_grant register.

Verification
REQ-037 Single fetch IF_Address=0x05 with MEM_MFC=1 -> MEM_r_w_z_z=00, MEM_Address=0x05, IF_Ack on the 4th cycle, IF_Data=ROM[5], Error=0.
REQ-038 DM write 0x40 <- 0xDEADBEEF, then DM read 0x40 -> MEM_r_w_z_z=01 then 00; read returns DM_Data_Out=0xDEADBEEF.
REQ-039 IF_Req and DM_Req raised on the same edge from reset -> DM served first, IF next; IF_Ack and DM_Ack never coincide.
REQ-040 DM read 0x80 with MEM_ERROR=1 -> no WAIT_MFC, DM_Ack with Error=1.
REQ-041 MEM_MFC held at 0 -> Ack with Error=1 exactly TIMEOUT_CYCLES=8 cycles after entry to WAIT_MFC.
REQ-042 Reset pulsed in WAIT_MFC -> no Ack, Busy=0, MEM_r_w_z_z=10; held request re-served after release.
